// File: rtl/prf_pkg.sv
// Shared definitions for the physical register file: init/run state
// encoding, index-width helper and the hardwired-zero register index.
package prf_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } prf_state_e;

    // Index of the register that reads as zero when the zero mode is on.
    localparam int ZERO_IDX = 0;

    // Bits needed to address n entries (never less than one bit).
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/prf_init_seq.sv
// Post-reset init sequencer for the physical register file. Walks a
// pointer across the array INIT_PER_CYCLE entries at a time, then parks
// in RUN until the next reset. o_init_done rises together with RUN.
module prf_init_seq
    import prf_pkg::*;
#(
    parameter  int SIZE           = 80,
    parameter  int INIT_PER_CYCLE = 8,
    localparam int PTR_W          = idx_width(SIZE + INIT_PER_CYCLE)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             o_run,
    output logic             o_clr_en,
    output logic [PTR_W-1:0] o_clr_base,
    output logic             o_init_done
);

    prf_state_e       r_state;
    logic [PTR_W-1:0] r_ptr;
    logic             r_init_done;

    // State, clear pointer and done flag; RUN is only left through reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= INIT;
            r_ptr       <= '0;
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                INIT: begin
                    r_ptr <= r_ptr + PTR_W'(INIT_PER_CYCLE);
                    // Last slice being cleared this cycle: enter RUN next.
                    if (int'(r_ptr) + INIT_PER_CYCLE >= SIZE) begin
                        r_state     <= RUN;
                        r_init_done <= 1'b1;
                    end
                end
                RUN: begin
                    r_state <= RUN;
                end
                default: begin
                    r_state <= INIT;
                end
            endcase
        end
    end

    assign o_run       = (r_state == RUN);
    assign o_clr_en    = (r_state == INIT);
    assign o_clr_base  = r_ptr;
    assign o_init_done = r_init_done;

endmodule

// File: rtl/prf_regfile.sv
// Physical integer register file with per-entry ready scoreboard.
// Registered 1-cycle reads with writeback bypass, combinational ready
// checks for dispatch, not-ready marks from rename, flush re-readies
// every entry, and a hardware init sweep after reset.
// Optional: define REGFILE_PARITY_EN to add per-entry even parity and a
// sticky o_parity_err output.
module prf_regfile
    import prf_pkg::*;
#(
    parameter  int DATA_WIDTH     = 64,
    parameter  int SIZE           = 80,
    parameter  int READPORT_NUM   = 10,
    parameter  int WBPORT_NUM     = 6,
    parameter  int MARK_NUM       = 4,
    parameter  int CHECK_NUM      = 8,
    parameter  int HAS_ZERO       = 1,
    parameter  int INIT_PER_CYCLE = 8,
    localparam int IDX_W          = idx_width(SIZE)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_flush,
    input  logic [MARK_NUM-1:0]                    i_notready_mark,
    input  logic [MARK_NUM-1:0][IDX_W-1:0]         i_notready_idx,
    input  logic [CHECK_NUM-1:0][IDX_W-1:0]        i_check_idx,
    output logic [CHECK_NUM-1:0]                   o_check_rdy,
    input  logic [READPORT_NUM-1:0][IDX_W-1:0]     i_read_idx,
    output logic [READPORT_NUM-1:0][DATA_WIDTH-1:0] o_read_data,
    output logic [READPORT_NUM-1:0]                o_data_rdy,
    input  logic [WBPORT_NUM-1:0]                  i_write_en,
    input  logic [WBPORT_NUM-1:0][IDX_W-1:0]       i_write_idx,
    input  logic [WBPORT_NUM-1:0][DATA_WIDTH-1:0]  i_write_data,
`ifdef REGFILE_PARITY_EN
    output logic                                   o_parity_err,
`endif
    output logic                                   o_init_done
);

    localparam int               PTR_W  = idx_width(SIZE + INIT_PER_CYCLE);
    localparam logic [IDX_W:0]   SIZE_X = (IDX_W + 1)'(SIZE);

    // Index lies inside the array.
    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        return ({1'b0, idx} < SIZE_X);
    endfunction

    // Index is the hardwired zero register.
    function automatic logic idx_zero(input logic [IDX_W-1:0] idx);
        return (HAS_ZERO != 0) && (idx == IDX_W'(ZERO_IDX));
    endfunction

    logic             w_run;
    logic             w_clr_en;
    logic [PTR_W-1:0] w_clr_base;

    prf_init_seq #(
        .SIZE           (SIZE),
        .INIT_PER_CYCLE (INIT_PER_CYCLE)
    ) u_init_seq (
        .clk         (clk),
        .rst         (rst),
        .o_run       (w_run),
        .o_clr_en    (w_clr_en),
        .o_clr_base  (w_clr_base),
        .o_init_done (o_init_done)
    );

    logic [DATA_WIDTH-1:0] r_data      [SIZE];
    logic [DATA_WIDTH-1:0] w_data_next [SIZE];
    logic [SIZE-1:0]       r_rdy;
    logic [SIZE-1:0]       w_rdy_next;
    logic [WBPORT_NUM-1:0] w_wr_valid;
`ifdef REGFILE_PARITY_EN
    logic [SIZE-1:0]         r_par;
    logic [SIZE-1:0]         w_par_next;
    logic [READPORT_NUM-1:0] w_par_bad;
    logic                    r_parity_err;
`endif

    // A write only lands on a real, non-zero register.
    generate
        for (genvar gi = 0; gi < WBPORT_NUM; gi++) begin : g_wr
            assign w_wr_valid[gi] = i_write_en[gi] && idx_ok(i_write_idx[gi])
                                    && !idx_zero(i_write_idx[gi]);
        end
    endgenerate

    // Next array state: init clear slice, else flush/marks then writes
    // (writes applied last so they beat a same-cycle mark).
    always_comb begin
        w_data_next = r_data;
        w_rdy_next  = r_rdy;
`ifdef REGFILE_PARITY_EN
        w_par_next  = r_par;
`endif
        if (w_clr_en) begin
            for (int e = 0; e < SIZE; e++) begin
                if (e >= int'(w_clr_base) && e < int'(w_clr_base) + INIT_PER_CYCLE) begin
                    w_data_next[e] = '0;
                    w_rdy_next[e]  = 1'b1;
`ifdef REGFILE_PARITY_EN
                    w_par_next[e]  = 1'b0;
`endif
                end
            end
        end else begin
            if (i_flush) begin
                w_rdy_next = '1;
            end else begin
                for (int m = 0; m < MARK_NUM; m++) begin
                    if (i_notready_mark[m] && idx_ok(i_notready_idx[m])) begin
                        w_rdy_next[i_notready_idx[m]] = 1'b0;
                    end
                end
            end
            for (int p = 0; p < WBPORT_NUM; p++) begin
                if (w_wr_valid[p]) begin
                    w_data_next[i_write_idx[p]] = i_write_data[p];
                    w_rdy_next[i_write_idx[p]]  = 1'b1;
`ifdef REGFILE_PARITY_EN
                    w_par_next[i_write_idx[p]]  = ^i_write_data[p];
`endif
                end
            end
        end
    end

    // Data storage carries no reset; the init sweep defines its contents.
    always_ff @(posedge clk) begin
        r_data <= w_data_next;
`ifdef REGFILE_PARITY_EN
        r_par  <= w_par_next;
`endif
    end

    // Ready scoreboard, all not-ready until the init sweep reaches each entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdy <= '0;
        end else begin
            r_rdy <= w_rdy_next;
        end
    end

    // Read ports: registered capture with writeback bypass.
    generate
        for (genvar gi = 0; gi < READPORT_NUM; gi++) begin : g_rd
            logic [IDX_W-1:0]      w_idx;
            logic                  w_byp;
            logic [DATA_WIDTH-1:0] w_byp_data;
            logic [DATA_WIDTH-1:0] r_q_data;
            logic                  r_q_rdy;

            assign w_idx = i_read_idx[gi];

            // Find a same-cycle writeback to the read index.
            always_comb begin
                w_byp      = 1'b0;
                w_byp_data = '0;
                for (int p = 0; p < WBPORT_NUM; p++) begin
                    if (w_wr_valid[p] && i_write_idx[p] == w_idx) begin
                        w_byp      = 1'b1;
                        w_byp_data = i_write_data[p];
                    end
                end
            end

            // Capture data and ready for the requested entry.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_q_data <= '0;
                    r_q_rdy  <= 1'b0;
                end else if (!w_run || !idx_ok(w_idx)) begin
                    r_q_data <= '0;
                    r_q_rdy  <= 1'b0;
                end else if (idx_zero(w_idx)) begin
                    r_q_data <= '0;
                    r_q_rdy  <= 1'b1;
                end else if (w_byp) begin
                    r_q_data <= w_byp_data;
                    r_q_rdy  <= 1'b1;
                end else begin
                    r_q_data <= r_data[w_idx];
                    r_q_rdy  <= r_rdy[w_idx];
                end
            end

            assign o_read_data[gi] = r_q_data;
            assign o_data_rdy[gi]  = r_q_rdy;

`ifdef REGFILE_PARITY_EN
            assign w_par_bad[gi] = w_run && idx_ok(w_idx) && !idx_zero(w_idx) && !w_byp
                                   && r_rdy[w_idx] && ((^r_data[w_idx]) != r_par[w_idx]);
`endif
        end
    endgenerate

    // Dispatch readiness checks; same-cycle writebacks count as ready.
    generate
        for (genvar gi = 0; gi < CHECK_NUM; gi++) begin : g_chk
            logic [IDX_W-1:0] w_idx;
            logic             w_wr_hit;

            assign w_idx = i_check_idx[gi];

            // Any valid writeback targeting the checked index.
            always_comb begin
                w_wr_hit = 1'b0;
                for (int p = 0; p < WBPORT_NUM; p++) begin
                    if (w_wr_valid[p] && i_write_idx[p] == w_idx) begin
                        w_wr_hit = 1'b1;
                    end
                end
            end

            assign o_check_rdy[gi] = w_run && idx_ok(w_idx)
                                     && (idx_zero(w_idx) || r_rdy[w_idx] || w_wr_hit);
        end
    endgenerate

`ifdef REGFILE_PARITY_EN
    // Sticky parity error, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_parity_err <= 1'b0;
        end else if (|w_par_bad) begin
            r_parity_err <= 1'b1;
        end
    end

    assign o_parity_err = r_parity_err;
`endif

    // Two enabled writebacks to one index in the same cycle is illegal.
    logic w_dup_wr;

    // Pairwise compare of enabled write indices.
    always_comb begin
        w_dup_wr = 1'b0;
        for (int a = 0; a < WBPORT_NUM; a++) begin
            for (int b = a + 1; b < WBPORT_NUM; b++) begin
                if (i_write_en[a] && i_write_en[b] && i_write_idx[a] == i_write_idx[b]) begin
                    w_dup_wr = 1'b1;
                end
            end
        end
    end

    a_no_dup_write: assert property (@(posedge clk) disable iff (!rst) !w_dup_wr);

endmodule
